// File: rtl/demux_1bit_1x4_tdm_if.sv
// Bundles the serial input, mode controls and lane/status outputs of the 1x4 TDM bit demultiplexer.
interface demux_1bit_1x4_tdm_if;
  logic EN;
  logic SYNC;
  logic EXT;
  logic S1;
  logic S0;
  logic D;
  logic O3;
  logic O2;
  logic O1;
  logic O0;
  logic SLOT1;
  logic SLOT0;
  logic FRAME;
  logic LOCK;

  modport master (
    output EN, SYNC, EXT, S1, S0, D,
    input  O3, O2, O1, O0, SLOT1, SLOT0, FRAME, LOCK
  );

  modport slave (
    input  EN, SYNC, EXT, S1, S0, D,
    output O3, O2, O1, O0, SLOT1, SLOT0, FRAME, LOCK
  );
endinterface

// File: rtl/demux_1bit_1x4_tdm.sv
// 1x4 bit demultiplexer: assembles a 4-slot TDM frame into lanes O3..O0 (slot 00 -> O3),
// or routes bits directly by external select when EXT is high.
module demux_1bit_1x4_tdm #(
  parameter logic [1:0] SYNC_SLOT = 2'b00,
  parameter logic [3:0] OUT_INIT  = 4'b0000
) (
  input logic CLK,
  input logic RST,
  demux_1bit_1x4_tdm_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] out_q, out_d;
  logic       frame_q, frame_d;
  logic [1:0] lane;
  logic [3:0] mask_set;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      slot_q   <= 2'b00;
      mask_q   <= 4'b0000;
      shadow_q <= 4'b0000;
      out_q    <= OUT_INIT;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      frame_q  <= frame_d;
    end
  end

  // shadow and mask are indexed by slot; output bit index is the inverted select (slot 00 -> O3)
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    frame_d  = 1'b0;
    lane     = ~{bus.S1, bus.S0};
    mask_set = mask_q;

    if (bus.EXT) begin
      if (bus.EN) begin
        out_d[lane] = bus.D;
      end
    end else if (bus.SYNC) begin
      state_d = RUN;
      mask_d  = 4'b0000;
      if (bus.EN) begin
        shadow_d[SYNC_SLOT] = bus.D;
        mask_d[SYNC_SLOT]   = 1'b1;
        slot_d              = SYNC_SLOT + 2'd1;
      end else begin
        slot_d = SYNC_SLOT;
      end
    end else if (state_q == RUN && bus.EN) begin
      shadow_d[slot_q] = bus.D;
      mask_set[slot_q] = 1'b1;
      mask_d           = mask_set;
      slot_d           = slot_q + 2'd1;
      if (slot_q == 2'b11) begin
        mask_d = 4'b0000;
        // a frame entered mid-way after re-sync never reaches a full mask and is dropped
        if (&mask_set) begin
          out_d   = {shadow_d[0], shadow_d[1], shadow_d[2], shadow_d[3]};
          frame_d = 1'b1;
        end
      end
    end
  end

  assign bus.O3    = out_q[3];
  assign bus.O2    = out_q[2];
  assign bus.O1    = out_q[1];
  assign bus.O0    = out_q[0];
  assign bus.SLOT1 = slot_q[1];
  assign bus.SLOT0 = slot_q[0];
  assign bus.FRAME = frame_q;
  assign bus.LOCK  = (state_q == RUN);

endmodule

// File: tb/tb_demux_1bit_1x4_tdm.sv
// Directed-vector bench: each applied vector queues its hand-computed post-edge outputs; a monitor checks them.
module tb_demux_1bit_1x4_tdm;

  logic CLK;
  logic RST;

  demux_1bit_1x4_tdm_if ifc ();

  demux_1bit_1x4_tdm dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.slave)
  );

  typedef struct {
    int         idx;
    logic [3:0] o;
    logic [1:0] slot;
    logic       frame;
    logic       lock;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_miss;
  int   n_issued;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic apply(input logic rst, input logic en, input logic sync, input logic ext,
                       input logic [1:0] s, input logic d,
                       input logic [3:0] o, input logic [1:0] slot,
                       input logic fr, input logic lk);
    exp_t e;
    @(negedge CLK);
    RST      = rst;
    ifc.EN   = en;
    ifc.SYNC = sync;
    ifc.EXT  = ext;
    ifc.S1   = s[1];
    ifc.S0   = s[0];
    ifc.D    = d;
    e.idx    = n_issued;
    e.o      = o;
    e.slot   = slot;
    e.frame  = fr;
    e.lock   = lk;
    exp_q.push_back(e);
    n_issued++;
  endtask

  // Monitor: checks the registered outputs 1 ns after each rising edge
  initial begin
    exp_t       e;
    logic [3:0] got_o;
    logic [1:0] got_slot;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        got_o    = {ifc.O3, ifc.O2, ifc.O1, ifc.O0};
        got_slot = {ifc.SLOT1, ifc.SLOT0};
        n_vec++;
        if (got_o !== e.o || got_slot !== e.slot || ifc.FRAME !== e.frame || ifc.LOCK !== e.lock) begin
          n_miss++;
          $display("FAIL vec%0d: got O=%b SLOT=%b FRAME=%b LOCK=%b, expected O=%b SLOT=%b FRAME=%b LOCK=%b",
                   e.idx, got_o, got_slot, ifc.FRAME, ifc.LOCK, e.o, e.slot, e.frame, e.lock);
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_miss = 0; n_issued = 0;
    RST = 1'b1;
    ifc.EN = 1'b0; ifc.SYNC = 1'b0; ifc.EXT = 1'b0;
    ifc.S1 = 1'b0; ifc.S0 = 1'b0; ifc.D = 1'b0;

    //     rst  en  sync ext s      d      O        slot   fr  lk
    // reset hold with activity, then IDLE ignores EN/D
    apply(1, 1, 0, 0, 2'd0, 1,  4'b0000, 2'd0, 0, 0);
    apply(1, 1, 0, 0, 2'd0, 1,  4'b0000, 2'd0, 0, 0);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b0000, 2'd0, 0, 0);
    // aligned frame 1011, then 0100
    apply(0, 1, 1, 0, 2'd0, 1,  4'b0000, 2'd1, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b0000, 2'd2, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b0000, 2'd3, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1011, 2'd0, 1, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b1011, 2'd1, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1011, 2'd2, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b1011, 2'd3, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b0100, 2'd0, 1, 1);
    apply(0, 0, 0, 0, 2'd0, 1,  4'b0100, 2'd0, 0, 1);
    // stall between slots 01 and 10, word 1101
    apply(0, 1, 0, 0, 2'd0, 1,  4'b0100, 2'd1, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b0100, 2'd2, 0, 1);
    apply(0, 0, 0, 0, 2'd0, 0,  4'b0100, 2'd2, 0, 1);
    apply(0, 0, 0, 0, 2'd0, 1,  4'b0100, 2'd2, 0, 1);
    apply(0, 0, 0, 0, 2'd0, 0,  4'b0100, 2'd2, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b0100, 2'd3, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1101, 2'd0, 1, 1);
    apply(0, 0, 0, 0, 2'd0, 0,  4'b1101, 2'd0, 0, 1);
    // mid-frame re-sync: partial frame discarded, new frame 0110
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1101, 2'd1, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b1101, 2'd2, 0, 1);
    apply(0, 1, 1, 0, 2'd0, 0,  4'b1101, 2'd1, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1101, 2'd2, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1101, 2'd3, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b0110, 2'd0, 1, 1);
    // SYNC without EN aligns counter to slot 00, then frame 0010
    apply(0, 0, 1, 0, 2'd0, 1,  4'b0110, 2'd0, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b0110, 2'd1, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b0110, 2'd2, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b0110, 2'd3, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b0010, 2'd0, 1, 1);
    // EXT mode mid-frame: direct lane writes, counter frozen, SYNC ignored, then resume
    apply(0, 1, 0, 0, 2'd0, 1,  4'b0010, 2'd1, 0, 1);
    apply(0, 1, 0, 1, 2'd3, 1,  4'b0011, 2'd1, 0, 1);
    apply(0, 1, 0, 1, 2'd0, 1,  4'b1011, 2'd1, 0, 1);
    apply(0, 1, 1, 1, 2'd1, 1,  4'b1111, 2'd1, 0, 1);
    apply(0, 0, 0, 1, 2'd2, 0,  4'b1111, 2'd1, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 0,  4'b1111, 2'd2, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1111, 2'd3, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1011, 2'd0, 1, 1);
    // reset mid-frame, then EN without SYNC captures nothing
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1011, 2'd1, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1011, 2'd2, 0, 1);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b1011, 2'd3, 0, 1);
    apply(1, 1, 0, 0, 2'd0, 1,  4'b0000, 2'd0, 0, 0);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b0000, 2'd0, 0, 0);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b0000, 2'd0, 0, 0);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b0000, 2'd0, 0, 0);
    apply(0, 1, 0, 0, 2'd0, 1,  4'b0000, 2'd0, 0, 0);
    // EXT works in IDLE; reset outranks EXT and SYNC
    apply(0, 1, 0, 1, 2'd2, 1,  4'b0010, 2'd0, 0, 0);
    apply(0, 1, 1, 0, 2'd0, 1,  4'b0010, 2'd1, 0, 1);
    apply(1, 1, 1, 1, 2'd3, 1,  4'b0000, 2'd0, 0, 0);

    @(negedge CLK);
    RST = 1'b0; ifc.EN = 1'b0; ifc.SYNC = 1'b0; ifc.EXT = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
